inv_key_expansion: RTL and testbench

//   AES-128 inverse key schedule. Takes the final round key (round 10) and

---
 rtl/inv_key_expansion.sv | 139 +++++++++++++
 tb/tb_inv_key_expansion.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: rebuilds round keys 10..0 from the last round key,
// one round per clock, plus the forward S-box shared with the forward schedule.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Byte 0 of the table sits in the top byte, so entry a lives at bit offset (255-a)*8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = {~a, 3'b000};
  assign y   = SBOX_TABLE[idx +: 8];
endmodule

module inv_key_expansion (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [127:0]       last_key_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [10:0][127:0] round_key_o,
  output logic [1:0]         state_dbg
);
  localparam int NR = 10;

  // Handshake: a key is taken on any rising edge where valid_i && ready_o.
  // ready_o drops for the whole RUN phase; valid_o is a one-cycle pulse in
  // DONE, and a new key may be taken in that same cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [10:0][127:0] rk;
  logic               accept;
  logic [127:0]       cur;
  logic [127:0]       nxt;
  logic [31:0]        w0, w1, w2, w3;
  logic [31:0]        rot, sub;
  logic [7:0]         rc;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign accept = valid_i && (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = RUN;
      RUN:     if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = valid_i ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select the key currently being walked backwards.
  always_comb begin
    cur = '0;
    for (int i = 0; i <= NR; i++) begin
      if (cnt == 4'(i)) cur = rk[i];
    end
  end

  assign w0  = cur[127:96];
  assign w1  = cur[95:64];
  assign w2  = cur[63:32];
  assign w3  = cur[31:0];
  assign rc  = rcon(cnt);
  // Undoing the XOR chain first recovers the previous key's last word (W3^W2),
  // which is what the forward schedule fed through RotWord/SubWord.
  assign rot = {w3[23:0] ^ w2[23:0], w3[31:24] ^ w2[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    sbox u_sbox (
      .a (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign nxt = {w0 ^ sub ^ {rc, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rk  <= '0;
    end else if (accept) begin
      rk[NR] <= last_key_i;
      cnt    <= 4'(NR);
    end else if (state == RUN) begin
      for (int i = 0; i < NR; i++) begin
        if (cnt == 4'(i + 1)) rk[i] <= nxt;
      end
      cnt <= cnt - 4'd1;
    end
  end

  assign ready_o     = (state != RUN);
  assign valid_o     = (state == DONE);
  assign round_key_o = rk;
  assign state_dbg   = state;
endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed and random checks of the AES-128 inverse key schedule against a
// forward key-expansion model held in the bench.

module tb_inv_key_expansion;
  logic               clk;
  logic               rst;
  logic               valid_i;
  logic [127:0]       last_key_i;
  logic               ready_o;
  logic               valid_o;
  logic [10:0][127:0] round_key_o;
  logic [1:0]         state_dbg;

  int checks;
  int failures;
  int pulses;

  inv_key_expansion dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .last_key_i  (last_key_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .round_key_o (round_key_o),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward-schedule reference model
  logic [2047:0] sb_tab;
  logic [7:0]    sb [256];
  logic [7:0]    rc_b [11];

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    sub_word = {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [10:0][127:0] fwd_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc_b[i/4];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) fwd_expand[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Scoreboard helpers
  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [10:0][127:0] exp);
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (round_key_o[r] !== exp[r]) begin
        failures++;
        $display("FAIL %s rk[%0d]: got %h expected %h", name, r, round_key_o[r], exp[r]);
      end
    end
  endtask

  // Pulse monitor
  always @(negedge clk) if (valid_o === 1'b1) pulses++;

  // Driver tasks (called at a negedge; return at a negedge)
  task automatic do_accept(input logic [127:0] key);
    check_val("ready_before_accept", 128'(ready_o), 128'd1);
    valid_i    = 1'b1;
    last_key_i = key;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_done(output int lat, input int inj, input logic [127:0] ik);
    lat = 1;
    while (valid_o !== 1'b1 && lat < 40) begin
      if (inj != 0 && lat == inj) begin
        check_val("busy_ready_low", 128'(ready_o), 128'd0);
        valid_i    = 1'b1;
        last_key_i = ik;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    valid_i = 1'b0;
    if (valid_o !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL timeout: valid_o not seen within %0d cycles", lat);
    end
  endtask

  typedef struct {
    logic [127:0] last_key;
    logic [127:0] exp0;
    logic [127:0] exp1;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int                 lat;
    int                 p0;
    logic [127:0]       key;
    logic [10:0][127:0] ek;

    checks   = 0;
    failures = 0;
    pulses   = 0;

    sb_tab = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    for (int i = 0; i < 256; i++) sb[i] = sb_tab[2047 - 8*i -: 8];
    rc_b = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    vecs[0] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'h000102030405060708090a0b0c0d0e0f,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[2] = '{128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                128'h0,
                128'h62636363626363636263636362636363};

    // Reset state
    rst        = 1'b1;
    valid_i    = 1'b0;
    last_key_i = '0;
    repeat (3) @(negedge clk);
    check_val("reset_ready", 128'(ready_o), 128'd1);
    check_val("reset_valid", 128'(valid_o), 128'd0);
    check_val("reset_state", 128'(state_dbg), 128'd0);
    check_all("reset_keys", '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int v = 0; v < 3; v++) begin
      p0 = pulses;
      do_accept(vecs[v].last_key);
      wait_done(lat, 0, '0);
      check_val("latency", 128'(lat), 128'd11);
      check_val("rk0", round_key_o[0], vecs[v].exp0);
      check_val("rk1", round_key_o[1], vecs[v].exp1);
      check_val("rk10", round_key_o[10], vecs[v].last_key);
      check_all("vec_model", fwd_expand(vecs[v].exp0));
      @(negedge clk);
      check_val("done_one_cycle", 128'(valid_o), 128'd0);
      check_val("idle_ready", 128'(ready_o), 128'd1);
      check_val("held_rk0", round_key_o[0], vecs[v].exp0);
      repeat (3) @(negedge clk);
      check_val("single_pulse", 128'(pulses - p0), 128'd1);
    end

    // Back-to-back: second key accepted in the valid_o cycle
    p0 = pulses;
    do_accept(vecs[0].last_key);
    wait_done(lat, 0, '0);
    check_val("b2b_lat1", 128'(lat), 128'd11);
    do_accept(vecs[1].last_key);
    wait_done(lat, 0, '0);
    check_val("b2b_lat2", 128'(lat), 128'd11);
    check_all("b2b_keys", fwd_expand(vecs[1].exp0));
    repeat (3) @(negedge clk);
    check_val("b2b_pulses", 128'(pulses - p0), 128'd2);

    // Busy: valid_i during RUN is ignored
    p0 = pulses;
    do_accept(vecs[0].last_key);
    wait_done(lat, 4, vecs[1].last_key);
    check_val("busy_lat", 128'(lat), 128'd11);
    check_all("busy_keys", fwd_expand(vecs[0].exp0));
    repeat (3) @(negedge clk);
    check_val("busy_pulses", 128'(pulses - p0), 128'd1);

    // Reset in the middle of RUN
    p0 = pulses;
    do_accept(vecs[1].last_key);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_mid_ready", 128'(ready_o), 128'd1);
    check_val("rst_mid_valid", 128'(valid_o), 128'd0);
    check_all("rst_mid_keys", '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_val("rst_mid_no_pulse", 128'(pulses - p0), 128'd0);
    do_accept(vecs[0].last_key);
    wait_done(lat, 0, '0);
    check_val("post_rst_lat", 128'(lat), 128'd11);
    check_all("post_rst_keys", fwd_expand(vecs[0].exp0));
    @(negedge clk);

    // Random keys round-tripped through the forward model
    for (int n = 0; n < 100; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ek  = fwd_expand(key);
      do_accept(ek[10]);
      wait_done(lat, 0, '0);
      check_val("rand_lat", 128'(lat), 128'd11);
      check_all("rand_keys", ek);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
